data_mem_lsu: RTL and testbench
===============================

Name: data_mem_lsu

Overview:
- Load/store unit between the core datapath and the word-organised data RAM (1024 x 32, single write strobe, combinational read gated by READ).
- Converts RV32I byte, halfword and word loads and stores into word RAM accesses.
- Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Multi-cycle handshake toward the core: REQ / BUSY / DONE.

Parameters:
- RAM_AW, 10, RAM word-address width; word index = ADDR[RAM_AW+1:2].
- SW_FAST, 1, when 1 a full-word SW skips the read phase.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- REQ  in  1  access request; sampled only in IDLE.
- WE  in  1  1 = store, 0 = load.
- FUNCT3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ADDR  in  32  byte address; bits above RAM_AW+1 ignored.
- WDATA  in  32  store data, right-aligned.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle completion pulse.
- RDATA  out  32  extended load result.
- FAULT  out  1  misaligned or illegal request; valid with DONE.
- RAM_READ  out  1  to RAM READ.
- RAM_WRITE  out  1  to RAM WRITE.
- RAM_ADDRESS  out  RAM_AW  to RAM ADDRESS.
- RAM_DATA_IN  out  32  to RAM DATA_IN.
- RAM_DATA_OUT  in  32  from RAM DATA_OUT.

Behaviour:
- Reset (async, RESET_N=0):
  - State returns to IDLE.
  - BUSY, DONE, FAULT, RAM_READ and RAM_WRITE go to 0 immediately.
  - RDATA, RAM_ADDRESS and RAM_DATA_IN go to 0.
  - All latched request fields are cleared.
  - Reset mid-operation aborts with no RAM write after RESET_N falls.
- States: IDLE, RD, WR, RESP. All outputs are decoded from registered state and registered request fields (no REQ-to-output combinational path).
- Accept:
  - On a rising edge with state IDLE and REQ=1, latch ADDR, FUNCT3, WE and WDATA.
  - REQ while BUSY=1 is ignored (not queued).
- Legality check (at accept):
  - FAULT if H/HU/SH has ADDR[0]=1.
  - FAULT if W has ADDR[1:0]!=0.
  - FAULT if a load uses FUNCT3 in {011, 110, 111}.
  - FAULT if a store uses FUNCT3 not in {000, 001, 010}.
  - A faulting request goes IDLE->RESP. There is no RAM access, RDATA holds, and FAULT=1 during the DONE cycle.
- Transitions for legal requests:
  - Load: IDLE->RD->RESP->IDLE.
  - SB/SH: IDLE->RD->WR->RESP->IDLE.
  - SW with SW_FAST=1: IDLE->WR->RESP->IDLE.
  - SW with SW_FAST=0: follows the SB/SH path.
- RD: RAM_READ=1, RAM_ADDRESS = latched word index; RAM_DATA_OUT is registered into a word buffer at the end of RD.
- WR:
  - RAM_WRITE=1, RAM_ADDRESS = word index, RAM_DATA_IN = merged word.
  - SB replaces lane ADDR[1:0] with WDATA[7:0].
  - SH replaces half ADDR[1] with WDATA[15:0].
  - SW writes WDATA.
  - Byte lanes are little-endian: lane 0 = bits 7:0.
- RESP: DONE=1 for exactly one cycle; the next state is IDLE unconditionally. A new REQ is accepted no earlier than the IDLE cycle after RESP.
- RDATA:
  - Loaded at the RD->RESP edge from the buffer path.
  - Selected lane or half is sign-extended (B, H) or zero-extended (BU, HU); W is passed through.
  - Holds its value until the next successful load.
- FAULT: registered at accept, cleared at the next accept.
- Latency from accept edge to DONE high:
  - load: 2 cycles.
  - SB/SH: 3 cycles.
  - SW fast: 2 cycles.
  - fault: 1 cycle.
- RAM_READ and RAM_WRITE are never high in the same cycle.
- RAM_ADDRESS and RAM_DATA_IN hold their last values when idle.
- Outside RD/WR, both RAM strobes are 0.

Test Plan:
- Reset then SW ADDR=0x10 WDATA=0xDEADBEEF -> one WR cycle with RAM_ADDRESS=4; DONE 2 cycles after accept; FAULT=0.
- After the above, LB ADDR=0x13 -> RDATA=0xFFFFFFDE; LBU ADDR=0x13 -> RDATA=0x000000DE; LH ADDR=0x10 -> 0xFFFFBEEF; LHU ADDR=0x12 -> 0x0000DEAD.
- SB ADDR=0x11 WDATA=0x55 -> RD then WR with RAM_DATA_IN=0xDEAD55EF; DONE 3 cycles after accept; LW 0x10 returns 0xDEAD55EF.
- LW ADDR=0x12 and SH ADDR=0x13 -> DONE 1 cycle after accept; FAULT=1; no RAM strobes; RDATA unchanged.
- REQ held high for 6 cycles with LW -> exactly 2 accepts; no request captured while BUSY=1.
- RESET_N pulsed low during WR of an SB -> RAM_WRITE drops immediately; BUSY=0; RDATA=0; state IDLE after release.

Source files
------------

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: load/store unit between the core and a word-organised data RAM.
// Byte/halfword/word RV32I accesses become word RAM accesses; sub-word stores
// use read-modify-write, loads are sign- or zero-extended. REQ/BUSY/DONE toward
// the core, all outputs decoded from registered state and request fields.
module data_mem_lsu #(
  parameter int RAM_AW  = 10,
  parameter bit SW_FAST = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              REQ,
  input  logic              WE,
  input  logic [2:0]        FUNCT3,
  input  logic [31:0]       ADDR,
  input  logic [31:0]       WDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic [31:0]       RDATA,
  output logic              FAULT,
  output logic              RAM_READ,
  output logic              RAM_WRITE,
  output logic [RAM_AW-1:0] RAM_ADDRESS,
  output logic [31:0]       RAM_DATA_IN,
  input  logic [31:0]       RAM_DATA_OUT
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  logic        req_we_p0;
  logic [2:0]  req_f3_p0;
  logic [1:0]  req_lane_p0;
  logic [31:0] req_wdata_p0;

  // Address bits above the RAM window are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ADDR[31:RAM_AW+2];

  // Illegal width code for the direction, or misaligned halfword/word.
  function automatic logic illegal_req(input logic we, input logic [2:0] f3,
                                       input logic [1:0] lane);
    logic bad;
    bad = 1'b1;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = lane[0];
      3'b010:  bad = |lane;
      3'b100:  bad = we;
      3'b101:  bad = we | lane[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Select the addressed byte/half of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] s;
    logic [31:0]        r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    s = '0;
    r = w;
    case (f3)
      3'b000:  begin s = b; r = s; end
      3'b001:  begin s = h; r = s; end
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Merge right-aligned store data into the old word (little-endian lanes).
  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] m;
    m = old;
    case (f3)
      3'b000:  m[{lane, 3'b000} +: 8] = wd[7:0];
      3'b001:  if (lane[1]) m[31:16] = wd[15:0];
               else         m[15:0]  = wd[15:0];
      default: m = wd;
    endcase
    return m;
  endfunction

  // Control strobes decode straight from the registered state.
  assign BUSY      = (state != IDLE);
  assign DONE      = (state == RESP);
  assign RAM_READ  = (state == RD);
  assign RAM_WRITE = (state == WR);

  // Access FSM: accept/latch, legality, RAM read, merge/write, response.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= IDLE;
      req_we_p0    <= 1'b0;
      req_f3_p0    <= '0;
      req_lane_p0  <= '0;
      req_wdata_p0 <= '0;
      FAULT        <= 1'b0;
      RDATA        <= '0;
      RAM_ADDRESS  <= '0;
      RAM_DATA_IN  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ) begin
            req_we_p0    <= WE;
            req_f3_p0    <= FUNCT3;
            req_lane_p0  <= ADDR[1:0];
            req_wdata_p0 <= WDATA;
            FAULT        <= illegal_req(WE, FUNCT3, ADDR[1:0]);
            if (illegal_req(WE, FUNCT3, ADDR[1:0])) begin
              state <= RESP;
            end else begin
              RAM_ADDRESS <= ADDR[RAM_AW+1:2];
              if (SW_FAST && WE && (FUNCT3 == 3'b010)) begin
                RAM_DATA_IN <= WDATA;
                state       <= WR;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: begin
          if (req_we_p0) begin
            RAM_DATA_IN <= store_merge(req_f3_p0, req_lane_p0, RAM_DATA_OUT, req_wdata_p0);
            state       <= WR;
          end else begin
            RDATA <= load_ext(req_f3_p0, req_lane_p0, RAM_DATA_OUT);
            state <= RESP;
          end
        end
        WR:      state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: randomized scoreboard bench for data_mem_lsu with a
// byte-addressed reference memory and a behavioural word RAM.
module tb_data_mem_lsu;
  localparam int RAM_AW = 10;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              REQ = 1'b0;
  logic              WE = 1'b0;
  logic [2:0]        FUNCT3 = '0;
  logic [31:0]       ADDR = '0;
  logic [31:0]       WDATA = '0;
  logic              BUSY, DONE, FAULT, RAM_READ, RAM_WRITE;
  logic [31:0]       RDATA, RAM_DATA_IN, RAM_DATA_OUT;
  logic [RAM_AW-1:0] RAM_ADDRESS;

  data_mem_lsu #(.RAM_AW(RAM_AW), .SW_FAST(1'b1)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ), .WE(WE), .FUNCT3(FUNCT3),
    .ADDR(ADDR), .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA),
    .FAULT(FAULT), .RAM_READ(RAM_READ), .RAM_WRITE(RAM_WRITE),
    .RAM_ADDRESS(RAM_ADDRESS), .RAM_DATA_IN(RAM_DATA_IN), .RAM_DATA_OUT(RAM_DATA_OUT)
  );

  always #5 CLK = ~CLK;

  // Behavioural data RAM: combinational read gated by READ, write on the edge.
  logic [31:0] ram [0:(1<<RAM_AW)-1];
  assign RAM_DATA_OUT = RAM_READ ? ram[RAM_ADDRESS] : 32'h0;
  always @(posedge CLK) if (RAM_WRITE) ram[RAM_ADDRESS] <= RAM_DATA_IN;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory plus the last loaded value.
  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    int          lat;
    int          issue;
    int          n_rd;
    int          n_wr;
    logic [31:0] widx;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  bmem [0:4095];
  logic [31:0] ref_rdata = '0;

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int ic);
    exp_t   e;
    int     sz, base, wbase;
    logic   flt;
    longint v;
    sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    flt   = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
    if (!flt && (int'(a[1:0]) % sz) != 0) flt = 1'b1;
    base  = int'(a[11:0]);
    wbase = base & ~3;
    e.issue = ic;
    e.fault = flt;
    e.widx  = {20'h0, a[11:2]};
    e.wdata = '0;
    e.n_rd  = 0;
    e.n_wr  = 0;
    if (flt) begin
      e.lat = 1;
    end else if (!we) begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v | (longint'(bmem[base+i]) << (8*i));
      if (!f3[2] && sz < 4 && v >= (longint'(1) << (8*sz-1))) v = v - (longint'(1) << (8*sz));
      ref_rdata = v[31:0];
      e.lat  = 2;
      e.n_rd = 1;
    end else begin
      for (int i = 0; i < sz; i++) bmem[base+i] = 8'(wd >> (8*i));
      e.wdata = {bmem[wbase+3], bmem[wbase+2], bmem[wbase+1], bmem[wbase]};
      e.lat   = (sz == 4) ? 2 : 3;
      e.n_rd  = (sz == 4) ? 0 : 1;
      e.n_wr  = 1;
    end
    e.rdata = ref_rdata;
    sbq.push_back(e);
  endtask

  // Called at posedge+1; waits for IDLE, then presents one request for one cycle.
  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 50) begin @(posedge CLK); #1; n++; end
    if (BUSY) chk("idle_timeout", 32'(BUSY), 32'h0);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    wait_idle();
    model(we, f3, a, wd, cyc);
    REQ = 1'b1; WE = we; FUNCT3 = f3; ADDR = a; WDATA = wd;
    @(posedge CLK); #1;
    REQ = 1'b0; WE = 1'($urandom); FUNCT3 = 3'($urandom); ADDR = $urandom; WDATA = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || BUSY) && n < 50) begin @(posedge CLK); #1; n++; end
    if (sbq.size() != 0) chk("drain_timeout", 32'(sbq.size()), 32'h0);
  endtask

  // Monitor: strobe sanity every cycle; pop and compare on each DONE.
  bit mon_en = 1'b0;
  int rd_seen = 0, wr_seen = 0, done_cnt = 0;
  always @(negedge CLK) begin : mon
    exp_t e;
    if (mon_en) begin
      if (RAM_READ && RAM_WRITE) chk("strobe_overlap", 32'h1, 32'h0);
      if (sbq.size() == 0) begin
        if (RAM_READ || RAM_WRITE || DONE)
          chk("spurious_activity", {29'h0, RAM_READ, RAM_WRITE, DONE}, 32'h0);
      end else begin
        e = sbq[0];
        if (RAM_READ) begin
          rd_seen++;
          chk("rd_addr", 32'(RAM_ADDRESS), e.widx);
        end
        if (RAM_WRITE) begin
          wr_seen++;
          chk("wr_addr", 32'(RAM_ADDRESS), e.widx);
          chk("wr_data", RAM_DATA_IN, e.wdata);
        end
        if (DONE) begin
          done_cnt++;
          void'(sbq.pop_front());
          chk("fault", 32'(FAULT), 32'(e.fault));
          chk("rdata", RDATA, e.rdata);
          chk("latency", 32'(cyc - e.issue), 32'(e.lat));
          chk("rd_cycles", 32'(rd_seen), 32'(e.n_rd));
          chk("wr_cycles", 32'(wr_seen), 32'(e.n_wr));
          rd_seen = 0;
          wr_seen = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] a, saved;
    logic [2:0]  f3;
    logic        we;
    int          k, d0, n;
    for (int i = 0; i < (1<<RAM_AW); i++) ram[i] = '0;
    for (int i = 0; i < 4096; i++) bmem[i] = '0;

    // Reset state
    @(posedge CLK); #1;
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_fault", 32'(FAULT), 0);
    chk("rst_strobes", {30'h0, RAM_READ, RAM_WRITE}, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_raddr", 32'(RAM_ADDRESS), 0);
    chk("rst_rdin", RAM_DATA_IN, 0);
    @(negedge CLK); RESET_N = 1'b1; mon_en = 1'b1;
    @(posedge CLK); #1;

    // Directed sequence
    issue(1, 3'b010, 32'h10, 32'hDEADBEEF);
    issue(0, 3'b000, 32'h13, 0); drain(); chk("tp_lb", RDATA, 32'hFFFFFFDE);
    issue(0, 3'b100, 32'h13, 0); drain(); chk("tp_lbu", RDATA, 32'h000000DE);
    issue(0, 3'b001, 32'h10, 0); drain(); chk("tp_lh", RDATA, 32'hFFFFBEEF);
    issue(0, 3'b101, 32'h12, 0); drain(); chk("tp_lhu", RDATA, 32'h0000DEAD);
    issue(1, 3'b000, 32'h11, 32'h55);
    issue(0, 3'b010, 32'h10, 0); drain(); chk("tp_sb_lw", RDATA, 32'hDEAD55EF);
    issue(0, 3'b010, 32'h12, 0);
    issue(1, 3'b001, 32'h13, 32'h1234); drain(); chk("tp_fault_rdata", RDATA, 32'hDEAD55EF);
    issue(1, 3'b000, 32'hFFFFF013, 32'hAB);  // upper address bits ignored
    issue(0, 3'b011, 32'h10, 0);
    issue(1, 3'b100, 32'h10, 0);

    // REQ held six cycles: exactly two accepts
    wait_idle();
    d0 = done_cnt;
    k  = cyc;
    model(0, 3'b010, 32'h10, 0, k);
    model(0, 3'b010, 32'h10, 0, k + 3);
    REQ = 1'b1; WE = 1'b0; FUNCT3 = 3'b010; ADDR = 32'h10;
    repeat (6) begin @(posedge CLK); #1; end
    REQ = 1'b0;
    drain();
    repeat (3) begin @(posedge CLK); #1; end
    chk("held_req_accepts", 32'(done_cnt - d0), 32'd2);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      a  = $urandom & 32'hFFFFF03F;
      f3 = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        else if (f3[1:0] != 2'd0) a[1:0] = 2'b00;
      end
      issue(we, f3, a, $urandom);
    end
    drain();

    // Reset during the WR cycle of an SB aborts the write
    saved = {bmem[8'h23], bmem[8'h22], bmem[8'h21], bmem[8'h20]};
    issue(1, 3'b000, 32'h21, 32'h77);
    n = 0;
    while (!RAM_WRITE && n < 10) begin @(posedge CLK); #1; n++; end
    chk("wr_reached", 32'(RAM_WRITE), 32'h1);
    #1; mon_en = 1'b0; RESET_N = 1'b0;
    #1;
    chk("arst_write", 32'(RAM_WRITE), 0);
    chk("arst_busy", 32'(BUSY), 0);
    chk("arst_rdata", RDATA, 0);
    chk("arst_done", 32'(DONE), 0);
    chk("arst_rdin", RAM_DATA_IN, 0);
    sbq.delete();
    {bmem[8'h23], bmem[8'h22], bmem[8'h21], bmem[8'h20]} = saved;
    ref_rdata = '0;
    rd_seen = 0; wr_seen = 0;
    @(posedge CLK); @(negedge CLK); RESET_N = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_idle", 32'(BUSY), 0);
    mon_en = 1'b1;
    issue(0, 3'b010, 32'h20, 0); drain();
    chk("post_rst_word", RDATA, saved);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
